// File: rtl/ram.sv
// Register-file RAM: one synchronous write port (writes every cycle) and two
// asynchronous read ports. Define RAM_BYPASS_EN for write-through forwarding.
module ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 1,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [ADDR_W-1:0] dest,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_hit;

  // Addresses beyond the implemented depth neither write nor read storage.
  assign wr_hit = 32'(dest) < 32'(DEPTH);

  always_comb begin
    // NOTE: start from the current contents so every entry is assigned on every path; no latch is inferred.
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_hit && (32'(dest) == 32'(i))) begin
        mem_d[i] = data;
      end
    end
  end

  // NOTE: the storage array is reset here because the datapath relies on all-zero contents after reset; non-blocking updates only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    out_a = '0;
    out_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(address_a) == 32'(i)) out_a = mem_q[i];
      if (32'(address_b) == 32'(i)) out_b = mem_q[i];
    end
`ifdef RAM_BYPASS_EN
    // Forward the in-flight write so a same-cycle read sees the new value.
    if (rst_n && wr_hit && (address_a == dest)) out_a = data;
    if (rst_n && wr_hit && (address_b == dest)) out_b = data;
`endif
  end

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: table-driven vectors plus hand sequences, with
// expectations queued in a scoreboard and compared between clock edges.
module tb_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] address_a, address_b, dest;
  logic [0:0] data, out_a, out_b;
  logic [3:0] address_a12, address_b12, dest12;
  logic [0:0] data12, out_a12, out_b12;

  ram #(.ADDR_W(4), .DATA_W(1), .DEPTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .address_a(address_a), .address_b(address_b),
    .dest(dest), .data(data),
    .out_a(out_a), .out_b(out_b)
  );

  ram #(.ADDR_W(4), .DATA_W(1), .DEPTH(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n),
    .address_a(address_a12), .address_b(address_b12),
    .dest(dest12), .data(data12),
    .out_a(out_a12), .out_b(out_b12)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    logic       sel;
    logic [0:0] ea;
    logic [0:0] eb;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    string      name;
    logic [3:0] dest;
    logic [0:0] data;
    logic [3:0] a;
    logic [3:0] b;
    logic [0:0] ea;
    logic [0:0] eb;
  } vec_t;

  vec_t vecs[8];

`ifdef RAM_BYPASS_EN
  localparam logic [0:0] RDW_PRE = 1'b1;
`else
  localparam logic [0:0] RDW_PRE = 1'b0;
`endif

  task automatic check(input string name, input logic [0:0] act, input logic [0:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic sel, input logic [0:0] ea,
                            input logic [0:0] eb);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.ea   = ea;
    e.eb   = eb;
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb_q.pop_front();
    if (e.sel) begin
      check({e.name, "/a12"}, out_a12, e.ea);
      check({e.name, "/b12"}, out_b12, e.eb);
    end else begin
      check({e.name, "/a"}, out_a, e.ea);
      check({e.name, "/b"}, out_b, e.eb);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] d, input logic [0:0] v,
                       input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    rst_n     = r;
    dest      = d;
    data      = v;
    address_a = a;
    address_b = b;
  endtask

  initial begin
    rst_n = 1'b0; dest = 4'd5; data = 1'b1; address_a = '0; address_b = '0;
    dest12 = '0; data12 = '0; address_a12 = '0; address_b12 = '0;

    // Two reset edges while a write to entry 5 is presented.
    repeat (2) @(posedge clk);
    for (int j = 0; j < 16; j++) begin
      drive(1'b0, 4'd5, 1'b1, 4'(j), 4'(15 - j));
      expect_out($sformatf("reset_rd%0d", j), 1'b0, 1'b0, 1'b0);
      #1 compare_out();
    end

    // Each vector: inputs driven, outputs checked before the edge that writes.
    vecs[0] = '{"wr1",       4'd1,  1'b1, 4'd2,  4'd3,  1'b0, 1'b0};
    vecs[1] = '{"rd1_wr7",   4'd7,  1'b1, 4'd1,  4'd3,  1'b1, 1'b0};
    vecs[2] = '{"dual7",     4'd8,  1'b0, 4'd7,  4'd7,  1'b1, 1'b1};
    vecs[3] = '{"wr7_zero",  4'd7,  1'b0, 4'd1,  4'd3,  1'b1, 1'b0};
    vecs[4] = '{"dual7_0",   4'd8,  1'b0, 4'd7,  4'd7,  1'b0, 1'b0};
    vecs[5] = '{"wr15",      4'd15, 1'b1, 4'd8,  4'd1,  1'b0, 1'b1};
    vecs[6] = '{"rd15_wr0",  4'd0,  1'b1, 4'd15, 4'd14, 1'b1, 1'b0};
    vecs[7] = '{"rd0_15",    4'd3,  1'b0, 4'd0,  4'd15, 1'b1, 1'b1};
    for (int i = 0; i < $size(vecs); i++) begin
      drive(1'b1, vecs[i].dest, vecs[i].data, vecs[i].a, vecs[i].b);
      expect_out(vecs[i].name, 1'b0, vecs[i].ea, vecs[i].eb);
      #1 compare_out();
    end

    // Read during write to the same entry.
    drive(1'b1, 4'd2, 1'b1, 4'd2, 4'd9);
    expect_out("rdw_pre", 1'b0, RDW_PRE, 1'b0);
    #1 compare_out();
    @(posedge clk);
    expect_out("rdw_post", 1'b0, 1'b1, 1'b0);
    #1 compare_out();

    // Continuous write sweep, checking the entry written the cycle before.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] prev;
      logic [0:0] pexp;
      prev = (i == 0) ? 4'd15 : 4'(i - 1);
      pexp = (i == 0) ? 1'b1 : 1'(((i - 1) % 2) == 0);
      drive(1'b1, 4'(i), 1'((i % 2) == 0), prev, prev);
      expect_out($sformatf("sweep%0d", i), 1'b0, pexp, pexp);
      #1 compare_out();
    end
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, 4'(j), 1'((j % 2) == 0), 4'(j), 4'(15 - j));
      expect_out($sformatf("pattern%0d", j), 1'b0, 1'((j % 2) == 0), 1'((j % 2) == 1));
      #1 compare_out();
    end

    // Single reset edge mid-operation, overriding the presented write.
    drive(1'b0, 4'd4, 1'b1, 4'd0, 4'd2);
    expect_out("prereset", 1'b0, 1'b1, 1'b1);
    #1 compare_out();
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, 4'(j), 1'b0, 4'(j), 4'((j + 8) % 16));
      expect_out($sformatf("postreset%0d", j), 1'b0, 1'b0, 1'b0);
      #1 compare_out();
    end

    // Out-of-range accesses on the 12-entry instance.
    @(negedge clk);
    dest12 = 4'd11; data12 = 1'b1; address_a12 = 4'd13; address_b12 = 4'd10;
    expect_out("oor_wr11", 1'b1, 1'b0, 1'b0);
    #1 compare_out();
    @(negedge clk);
    dest12 = 4'd13; data12 = 1'b1; address_a12 = 4'd13; address_b12 = 4'd11;
    expect_out("oor_wr13", 1'b1, 1'b0, 1'b1);
    #1 compare_out();
    @(negedge clk);
    dest12 = 4'd12; data12 = 1'b1; address_a12 = 4'd12; address_b12 = 4'd11;
    expect_out("oor_wr12", 1'b1, 1'b0, 1'b1);
    #1 compare_out();
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      dest12 = 4'd15; data12 = 1'b1; address_a12 = 4'(j); address_b12 = 4'(j + 4);
      expect_out($sformatf("oor_rd%0d", j), 1'b1, 1'(j == 11), 1'((j + 4) == 11));
      #1 compare_out();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
